// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch FSM states and
// the NOP encoding used when seeding instruction streams.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // Width of a counter that must hold 0..t; never narrower than one bit.
    function automatic int ctr_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait-cycle counter for an outstanding memory request;
// expired_o flags the last cycle the request may still be acked.
module fetch_timeout_ctr
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = ctr_width(TIMEOUT_CYCLES);
    localparam int SAT_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : (1 << CW) - 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] SAT  = CW'(SAT_I);
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_on
        assign expired_o = (cnt_q == LAST);
    end else begin : g_off
        assign expired_o = 1'b0;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding instruction memory reads, output
// register toward decode, PC stall and branch flush handling.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_taken,
    output logic              pc_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic              err_q, err_d;

    logic launch;
    logic xfer;
    logic busy;
    logic expired;
    logic timeout;
    logic load;

    assign busy    = (state_q != S_IDLE);
    assign xfer    = req_q && imem_ack;
    assign timeout = busy && !imem_ack && expired;

    // A launch needs a free or draining output slot, so a transfer never overflows.
    assign launch = (state_q == S_IDLE) && !err_q && !branch_taken
                    && (!ov_q || out_ready);

    assign pc_stall = reset || !launch;

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (launch),
        .en_i     (busy && !imem_ack),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        err_d   = err_q;
        load    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (xfer) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    load    = !branch_taken;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (branch_taken) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (xfer) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ov_d    = ov_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        if (load) begin
            ov_d    = 1'b1;
            instr_d = imem_rdata;
            opc_d   = addr_q;
        end
        // A taken branch makes whatever sits in the slot stale.
        if (branch_taken) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ov_q    <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ov_q    <= ov_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            err_q   <= err_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = ov_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table plus
// hand sequences for timeout and asynchronous reset.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NV = 26;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc_in = '0;
    logic          branch_taken = 1'b0;
    logic          pc_stall;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = NOP_INSTR;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          fetch_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .branch_taken(branch_taken),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fetch_err   (fetch_err)
    );

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] pc;
        logic          br;
        logic          ack;
        logic [DW-1:0] rdata;
        logic          rdy;
        logic          e_stall;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_ov;
        logic [DW-1:0] e_instr;
        logic [AW-1:0] e_opc;
        logic          e_err;
    } vec_t;

    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [AW-1:0] pc,
                         input logic br, input logic ack,
                         input logic [DW-1:0] rd, input logic rdy);
        @(negedge clk);
        reset        = rst;
        pc_in        = pc;
        branch_taken = br;
        imem_ack     = ack;
        imem_rdata   = rd;
        out_ready    = rdy;
        #1;
    endtask

    initial begin
        // rst pc br ack rdata rdy | stall req addr ov instr opc err
        vec[0]  = '{1,16'h0000,0,0,16'h0000,1, 1,0,16'h0000,0,16'h0000,16'h0000,0};
        vec[1]  = '{0,16'h0000,0,0,16'h0000,1, 0,0,16'h0000,0,16'h0000,16'h0000,0};
        vec[2]  = '{0,16'h0001,0,1,16'hA000,1, 1,1,16'h0000,0,16'h0000,16'h0000,0};
        vec[3]  = '{0,16'h0001,0,0,16'h0000,1, 0,0,16'h0000,1,16'hA000,16'h0000,0};
        vec[4]  = '{0,16'h0002,0,1,16'hA001,1, 1,1,16'h0001,0,16'hA000,16'h0000,0};
        vec[5]  = '{0,16'h0002,0,0,16'h0000,1, 0,0,16'h0001,1,16'hA001,16'h0001,0};
        vec[6]  = '{0,16'h0003,0,1,16'hA002,1, 1,1,16'h0002,0,16'hA001,16'h0001,0};
        vec[7]  = '{0,16'h0003,0,0,16'h0000,0, 1,0,16'h0002,1,16'hA002,16'h0002,0};
        vec[8]  = '{0,16'h0003,0,0,16'h0000,0, 1,0,16'h0002,1,16'hA002,16'h0002,0};
        vec[9]  = '{0,16'h0003,0,0,16'h0000,1, 0,0,16'h0002,1,16'hA002,16'h0002,0};
        vec[10] = '{0,16'h0004,0,0,16'h0000,1, 1,1,16'h0003,0,16'hA002,16'h0002,0};
        vec[11] = '{0,16'h0040,1,0,16'h0000,1, 1,1,16'h0003,0,16'hA002,16'h0002,0};
        vec[12] = '{0,16'h0040,0,0,16'h0000,1, 1,1,16'h0003,0,16'hA002,16'h0002,0};
        vec[13] = '{0,16'h0040,0,1,16'hBEEF,1, 1,1,16'h0003,0,16'hA002,16'h0002,0};
        vec[14] = '{0,16'h0040,0,0,16'h0000,1, 0,0,16'h0003,0,16'hA002,16'h0002,0};
        vec[15] = '{0,16'h0041,0,0,16'h0000,1, 1,1,16'h0040,0,16'hA002,16'h0002,0};
        vec[16] = '{0,16'h0080,1,1,16'hDEAD,1, 1,1,16'h0040,0,16'hA002,16'h0002,0};
        vec[17] = '{0,16'h0080,0,0,16'h0000,1, 0,0,16'h0040,0,16'hA002,16'h0002,0};
        vec[18] = '{0,16'h0081,0,1,16'hC080,0, 1,1,16'h0080,0,16'hA002,16'h0002,0};
        vec[19] = '{0,16'h0081,0,0,16'h0000,0, 1,0,16'h0080,1,16'hC080,16'h0080,0};
        vec[20] = '{0,16'h0100,1,0,16'h0000,0, 1,0,16'h0080,1,16'hC080,16'h0080,0};
        vec[21] = '{0,16'h0100,0,0,16'h0000,0, 0,0,16'h0080,0,16'hC080,16'h0080,0};
        vec[22] = '{0,16'h0101,0,1,16'hC100,1, 1,1,16'h0100,0,16'hC080,16'h0080,0};
        vec[23] = '{0,16'h0101,0,0,16'h0000,1, 0,0,16'h0100,1,16'hC100,16'h0100,0};
        vec[24] = '{0,16'h0102,0,1,16'hC101,1, 1,1,16'h0101,0,16'hC100,16'h0100,0};
        vec[25] = '{0,16'h0102,0,0,16'h0000,0, 1,0,16'h0101,1,16'hC101,16'h0101,0};

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].rst, vec[i].pc, vec[i].br, vec[i].ack,
                  vec[i].rdata, vec[i].rdy);
            chk($sformatf("v%0d stall", i), 32'(pc_stall), 32'(vec[i].e_stall));
            chk($sformatf("v%0d req", i), 32'(imem_req), 32'(vec[i].e_req));
            chk($sformatf("v%0d addr", i), 32'(imem_addr), 32'(vec[i].e_addr));
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vec[i].e_ov));
            chk($sformatf("v%0d instr", i), 32'(out_instr), 32'(vec[i].e_instr));
            chk($sformatf("v%0d opc", i), 32'(out_pc), 32'(vec[i].e_opc));
            chk($sformatf("v%0d err", i), 32'(fetch_err), 32'(vec[i].e_err));
        end

        // Timeout: memory never acks, eight request cycles then fetch_err.
        drive(1, 16'h0200, 0, 0, 16'h0000, 1);
        chk("to rst stall", 32'(pc_stall), 32'd1);
        drive(0, 16'h0200, 0, 0, 16'h0000, 1);
        chk("to launch stall", 32'(pc_stall), 32'd0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 16'h0201, 0, 0, 16'h0000, 1);
            chk($sformatf("to w%0d req", k), 32'(imem_req), 32'd1);
            chk($sformatf("to w%0d err", k), 32'(fetch_err), 32'd0);
            chk($sformatf("to w%0d stall", k), 32'(pc_stall), 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 16'h0201, 0, 0, 16'h0000, 1);
            chk($sformatf("to h%0d err", k), 32'(fetch_err), 32'd1);
            chk($sformatf("to h%0d req", k), 32'(imem_req), 32'd0);
            chk($sformatf("to h%0d stall", k), 32'(pc_stall), 32'd1);
        end
        chk("to addr", 32'(imem_addr), 32'h0200);

        // Async reset between edges clears the sticky error at once.
        reset = 1'b1;
        #1;
        chk("ar err clr", 32'(fetch_err), 32'd0);
        chk("ar stall", 32'(pc_stall), 32'd1);

        drive(0, 16'h0300, 0, 0, 16'h0000, 1);
        chk("ar2 launch", 32'(pc_stall), 32'd0);
        drive(0, 16'h0301, 0, 0, 16'h0000, 1);
        chk("ar2 req", 32'(imem_req), 32'd1);
        chk("ar2 addr", 32'(imem_addr), 32'h0300);

        // Async reset in the middle of an outstanding request.
        reset = 1'b1;
        #1;
        chk("ar3 req", 32'(imem_req), 32'd0);
        chk("ar3 valid", 32'(out_valid), 32'd0);
        chk("ar3 err", 32'(fetch_err), 32'd0);
        chk("ar3 addr", 32'(imem_addr), 32'd0);
        chk("ar3 stall", 32'(pc_stall), 32'd1);

        drive(0, 16'h0400, 0, 0, 16'h0000, 1);
        chk("rl launch", 32'(pc_stall), 32'd0);
        drive(0, 16'h0401, 0, 1, 16'h1234, 1);
        chk("rl req", 32'(imem_req), 32'd1);
        chk("rl addr", 32'(imem_addr), 32'h0400);
        drive(0, 16'h0401, 0, 0, 16'h0000, 0);
        chk("rl valid", 32'(out_valid), 32'd1);
        chk("rl instr", 32'(out_instr), 32'h1234);
        chk("rl opc", 32'(out_pc), 32'h0400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
